// File: rtl/mult_pkg.sv
// Shared definitions for the Wallace-tree multiplier controller.
//   - FSM state encoding (IDLE / EVAL / DONE)
//   - default operand width and result latency
//   - constant helpers that size the 3:2 carry-save reduction tree
package mult_pkg;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_LATENCY = 2;
  // cycle counter must hold LATENCY (max 7) after the capture increment
  localparam int CNT_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  // rows left after one level of 3:2 compression
  function automatic int csa_rows(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  // rows present at reduction level lvl (level 0 = partial products)
  function automatic int csa_rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) r = csa_rows(r);
    return r;
  endfunction

  // levels needed to bring n rows down to two
  function automatic int csa_levels(input int n);
    int r;
    int k;
    r = n;
    k = 0;
    while (r > 2) begin
      r = csa_rows(r);
      k++;
    end
    return k;
  endfunction

endpackage

// File: rtl/wallace_tree_32b.sv
// Combinational signed multiplier: two's complement partial products
// reduced by a Wallace tree of 3:2 compressors, then one final adder.
//   a_i  [WIDTH]   signed multiplicand
//   b_i  [WIDTH]   signed multiplier
//   p_o  [2*WIDTH] full signed product
module wallace_tree_32b
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int PW = 2 * WIDTH;
  // WIDTH shifted rows plus one row carrying the +1 of the MSB negation
  localparam int NR = WIDTH + 1;
  localparam int NL = csa_levels(NR);

  logic [PW-1:0] a_sx;
  assign a_sx = {{WIDTH{a_i[WIDTH-1]}}, a_i};

  // Each level is its own array so the tree has no self-referencing net.
  for (genvar l = 0; l <= NL; l++) begin : g_lvl
    localparam int N = csa_rows_at(NR, l);
    logic [PW-1:0] r [N];

    if (l == 0) begin : g_pp
      for (genvar i = 0; i < WIDTH - 1; i++) begin : g_row
        assign r[i] = b_i[i] ? (a_sx << i) : '0;
      end
      // b's MSB has negative weight: -(x) = ~x + 1, the +1 is its own row
      assign r[WIDTH-1] = b_i[WIDTH-1] ? ~(a_sx << (WIDTH - 1)) : '0;
      assign r[WIDTH]   = PW'(b_i[WIDTH-1]);
    end else begin : g_red
      localparam int P = csa_rows_at(NR, l - 1);
      localparam int G = P / 3;
      for (genvar g = 0; g < G; g++) begin : g_csa
        logic [PW-1:0] x, y, z;
        assign x = g_lvl[l-1].r[3*g];
        assign y = g_lvl[l-1].r[3*g+1];
        assign z = g_lvl[l-1].r[3*g+2];
        assign r[2*g]   = x ^ y ^ z;
        assign r[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
      end
      // leftover rows that did not fill a compressor pass straight down
      for (genvar k = 0; k < P - 3 * G; k++) begin : g_pass
        assign r[2*G+k] = g_lvl[l-1].r[3*G+k];
      end
    end
  end

  assign p_o = g_lvl[NL].r[0] + g_lvl[NL].r[1];

endmodule

// File: rtl/wallace_mult_ctrl.sv
// Sequenced signed multiplier. A ctrl_MULT pulse latches the operands and
// starts a LATENCY-edge evaluation; the registered product, overflow flag
// and a one-cycle ready pulse follow. A new ctrl_MULT always restarts.
//   clock, reset       rising-edge clock, synchronous active-high reset
//   ctrl_MULT          start; operands sampled on the same edge
//   data_operandA/B    signed operands [WIDTH]
//   data_result        low WIDTH bits of product (registered, held)
//   data_exception     signed overflow of the WIDTH-bit result (registered)
//   data_resultRDY     one-cycle completion pulse (registered)
//   busy               high while evaluating
module wallace_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH   = MULT_WIDTH,
  parameter int LATENCY = MULT_LATENCY
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic               exc_q, exc_d, rdy_q, rdy_d;
  logic               cap;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_hi;

  // fed only from the operand registers, so no input reaches an output
  wallace_tree_32b #(.WIDTH(WIDTH)) u_tree (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  // the WIDTH-bit result is exact only when these bits are a sign extension
  assign prod_hi = prod[2*WIDTH-1:WIDTH-1];

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) state_d = EVAL;
    else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        EVAL:    if (cnt_q == LAST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state_q == EVAL);
    cap   = (state_q == EVAL) && !ctrl_MULT && (cnt_q == LAST);
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    res_d = res_q;
    exc_d = exc_q;
    rdy_d = cap;
    if (ctrl_MULT) begin
      a_d   = data_operandA;
      b_d   = data_operandB;
      cnt_d = '0;
    end else if (state_q == EVAL) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cap) begin
      res_d = prod[WIDTH-1:0];
      exc_d = !((&prod_hi) || !(|prod_hi));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      exc_q <= exc_d;
      rdy_q <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_wallace_mult_ctrl.sv
// Self-checking bench for wallace_mult_ctrl. A transaction-level model
// (start edge + LATENCY = due edge, product by plain integer arithmetic)
// predicts every output after every edge; directed steps add explicit
// checks for the key scenarios.
module tb_wallace_mult_ctrl;

  localparam int W = 32;
  localparam int L = 2;

  logic         clock, reset, ctrl_MULT;
  logic [W-1:0] data_operandA, data_operandB, data_result;
  logic         data_exception, data_resultRDY, busy;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // model state: one pending operation at most
  logic         pend  = 1'b0;
  int           due   = 0;
  logic [W-1:0] pa    = '0;
  logic [W-1:0] pb    = '0;
  logic [W-1:0] m_res = '0;
  logic         m_exc = 1'b0;
  logic         m_rdy = 1'b0;

  wallace_mult_ctrl #(.WIDTH(W), .LATENCY(L)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  function automatic void ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] res, output logic exc);
    longint p, hi, lo;
    p   = longint'($signed(a)) * longint'($signed(b));
    hi  = (longint'(1) << (W - 1)) - 1;
    lo  = -(longint'(1) << (W - 1));
    res = p[W-1:0];
    exc = (p > hi) || (p < lo);
  endfunction

  // drive one edge's inputs, advance, update the model and compare
  task automatic cyc(input logic c, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    ctrl_MULT     = c;
    data_operandA = a;
    data_operandB = b;
    reset         = r;
    @(posedge clock);
    #1;
    edge_n++;
    m_rdy = 1'b0;
    if (r) begin
      pend  = 1'b0;
      m_res = '0;
      m_exc = 1'b0;
    end else if (c) begin
      pend = 1'b1;
      due  = edge_n + L;
      pa   = a;
      pb   = b;
    end else if (pend && edge_n == due) begin
      pend  = 1'b0;
      m_rdy = 1'b1;
      ref_mult(pa, pb, m_res, m_exc);
    end
    chk("cyc_rdy",    W'(data_resultRDY), W'(m_rdy));
    chk("cyc_busy",   W'(busy),           W'(pend));
    chk("cyc_result", data_result,        m_res);
    chk("cyc_exc",    W'(data_exception), W'(m_exc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, W'($urandom), W'($urandom), 1'b0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = W'($urandom);
      1:       v = W'(int'($urandom_range(0, 15)) - 8);
      2: begin
        case ($urandom_range(0, 4))
          0:       v = 32'h8000_0000;
          1:       v = 32'h7fff_ffff;
          2:       v = 32'hffff_ffff;
          3:       v = 32'h0000_0001;
          default: v = '0;
        endcase
      end
      default: v = W'($urandom) >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  initial begin
    int pulses;
    int e1, e2;
    ctrl_MULT     = 1'b0;
    reset         = 1'b1;
    data_operandA = '0;
    data_operandB = '0;

    // reset state
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    chk("rst_result", data_result, '0);
    chk("rst_rdy",    W'(data_resultRDY), '0);
    chk("rst_busy",   W'(busy), '0);

    // 7 * -3, ready exactly at edge 2
    cyc(1'b1, 32'd7, 32'hffff_fffd, 1'b0);
    chk("t031_busy_e0", W'(busy), 32'd1);
    idle(1);
    chk("t031_rdy_e1", W'(data_resultRDY), 32'd0);
    idle(1);
    chk("t031_rdy_e2", W'(data_resultRDY), 32'd1);
    chk("t031_result", data_result, 32'hffff_ffeb);
    chk("t031_exc",    W'(data_exception), 32'd0);
    idle(1);
    chk("t031_rdy_e3", W'(data_resultRDY), 32'd0);

    // overflow corners
    cyc(1'b1, 32'h8000_0000, 32'hffff_ffff, 1'b0);
    idle(2);
    chk("t032_minneg_res", data_result, 32'h8000_0000);
    chk("t032_minneg_exc", W'(data_exception), 32'd1);
    idle(1);
    cyc(1'b1, 32'd65536, 32'd65536, 1'b0);
    idle(2);
    chk("t032_2p32_res", data_result, 32'd0);
    chk("t032_2p32_exc", W'(data_exception), 32'd1);
    idle(1);

    // abort by restart: only the second operation completes
    cyc(1'b1, 32'd5, 32'd6, 1'b0);
    cyc(1'b1, 32'd3, 32'd4, 1'b0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (data_resultRDY === 1'b1) pulses++;
    end
    chk("t033_pulses", W'(pulses), 32'd1);
    chk("t033_result", data_result, 32'd12);

    // reset one cycle after start
    cyc(1'b1, 32'd9, 32'd9, 1'b0);
    cyc(1'b0, 32'd1, 32'd1, 1'b1);
    chk("t034_result", data_result, '0);
    chk("t034_exc",    W'(data_exception), '0);
    chk("t034_rdy",    W'(data_resultRDY), '0);
    chk("t034_busy",   W'(busy), '0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (data_resultRDY === 1'b1) pulses++;
    end
    chk("t034_pulses", W'(pulses), 32'd0);

    // start in the DONE cycle: both pulses appear
    cyc(1'b1, 32'd11, 32'd13, 1'b0);
    idle(2);
    e1 = edge_n;
    chk("t035_rdy1", W'(data_resultRDY), 32'd1);
    chk("t035_res1", data_result, 32'd143);
    cyc(1'b1, 32'hffff_fffb, 32'd100, 1'b0);
    idle(2);
    e2 = edge_n;
    chk("t035_rdy2", W'(data_resultRDY), 32'd1);
    chk("t035_res2", data_result, 32'hffff_fe0c);
    chk("t035_gap",  W'(e2 - e1), W'(L + 1));
    idle(1);

    // start held high never completes
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, rnd_op(), rnd_op(), 1'b0);
      if (data_resultRDY === 1'b1) pulses++;
    end
    chk("t023_pulses", W'(pulses), 32'd0);
    idle(3);

    // small signed sweep, back-to-back starts in the DONE cycle
    for (int a = -8; a <= 7; a++) begin
      for (int b = -8; b <= 7; b++) begin
        cyc(1'b1, W'(a), W'(b), 1'b0);
        idle(2);
        chk("sweep_rdy", W'(data_resultRDY), 32'd1);
        chk("sweep_res", data_result, W'(a * b));
        chk("sweep_exc", W'(data_exception), 32'd0);
      end
    end
    idle(2);

    // random traffic: starts, restarts, resets, idle operand noise
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 3) == 0, rnd_op(), rnd_op(), $urandom_range(0, 63) == 0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
